kbd_event_scheduler: RTL and testbench

- Sequences the data_ready / keyboard_data_retrieved handshake of the keyboard/mouse serial receiver.
- Drains each received keyboard or mouse word into a small tagged event FIFO.
- Presents events to the CPU-side register logic through a valid/ack port and raises an interrupt.
- Decouples the slow serial link from bus read timing and makes event loss detectable (sticky overflow) instead of silent overwrite.

---
 rtl/kbd_pkg.sv | 14 +
 rtl/kbd_event_fifo.sv | 70 +++++++
 rtl/kbd_event_scheduler.sv | 108 ++++++++++
 tb/tb_kbd_event_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and field layout for the keyboard/mouse event scheduler.
package kbd_pkg;

  localparam int KBD_EVENT_W  = 17;
  localparam int EV_MOUSE_BIT = 16;
  localparam int EV_DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy outputs.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int WIDTH  = KBD_EVENT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   count_nxt
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en, rd_en;

  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Flush wins over both ports; a pop in the same cycle makes room for a push.
  assign rd_en = pop & ~empty & ~flush;
  assign wr_en = push & ~flush & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/kbd_event_scheduler.sv
// Keyboard/mouse receiver handshake sequencer feeding a tagged event FIFO with irq.
//   state    | meaning
//   IDLE     | waiting for kb_data_ready; captures the word on the edge it is seen
//   ACK      | kb_data_retrieved pulse for this single cycle
//   WAIT_LOW | holding until the receiver drops kb_data_ready
module kbd_event_scheduler
  import kbd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kb_data_ready,
  input  logic              kb_is_mouse,
  input  logic [15:0]       kb_data,
  output logic              kb_data_retrieved,
  output logic              ev_valid,
  output logic              ev_is_mouse,
  output logic [15:0]       ev_data,
  input  logic              ev_ack,
  input  logic              flush,
  input  logic              irq_en,
  output logic              irq,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [ADDR_W:0]   count
);

  cap_state_e             state_q, state_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;
  logic                   capture, drop, push, pop_ok;
  logic                   full, empty;
  logic [KBD_EVENT_W-1:0] head;
  logic [ADDR_W:0]        count_nxt;

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .WIDTH (KBD_EVENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    ({kb_is_mouse, kb_data}),
    .pop      (ev_ack),
    .flush    (flush),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .count_nxt(count_nxt)
  );

  always_comb begin
    state_d           = state_q;
    capture           = 1'b0;
    kb_data_retrieved = 1'b0;
    case (state_q)
      IDLE: begin
        if (kb_data_ready) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        kb_data_retrieved = 1'b1;
        state_d           = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!kb_data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_ok = ev_ack & ~empty;
  assign drop   = capture & full & ~pop_ok;
  assign push   = capture & ~drop;

  // A flush leaves the sticky overflow flag untouched, even if it races a drop.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop && !flush) overflow_d = 1'b1;
    irq_d = irq_en & ((count_nxt != '0) | overflow_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign ev_valid    = ~empty;
  assign ev_is_mouse = ev_valid & head[EV_MOUSE_BIT];
  assign ev_data     = ev_valid ? head[EV_DATA_W-1:0] : '0;
  assign overflow    = overflow_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Scoreboard bench for kbd_event_scheduler: queued expected events checked on pop.
module tb_kbd_event_scheduler;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              kb_data_ready = 1'b0;
  logic              kb_is_mouse = 1'b0;
  logic [15:0]       kb_data = '0;
  logic              kb_data_retrieved;
  logic              ev_valid;
  logic              ev_is_mouse;
  logic [15:0]       ev_data;
  logic              ev_ack = 1'b0;
  logic              flush = 1'b0;
  logic              irq_en = 1'b0;
  logic              irq;
  logic              overflow;
  logic              overflow_clr = 1'b0;
  logic [ADDR_W:0]   count;

  kbd_event_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .kb_data_ready    (kb_data_ready),
    .kb_is_mouse      (kb_is_mouse),
    .kb_data          (kb_data),
    .kb_data_retrieved(kb_data_retrieved),
    .ev_valid         (ev_valid),
    .ev_is_mouse      (ev_is_mouse),
    .ev_data          (ev_data),
    .ev_ack           (ev_ack),
    .flush            (flush),
    .irq_en           (irq_en),
    .irq              (irq),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr),
    .count            (count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ret_cnt = 0;
  logic [16:0] sb_q[$];
  int          mcount = 0;
  bit          mov = 1'b0;

  always @(negedge clk) if (rst_n && kb_data_retrieved) ret_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic send_word(input logic m, input logic [15:0] d, input int extra,
                           input bit ack, input bit fl);
    int r0;
    bit seen;
    bit was_empty;
    r0 = ret_cnt;
    @(posedge clk); #1;
    kb_data_ready = 1'b1; kb_is_mouse = m; kb_data = d; ev_ack = ack; flush = fl;
    if (ack && sb_q.size() > 0) check("ack_head", {ev_is_mouse, ev_data}, sb_q[0]);
    was_empty = (sb_q.size() == 0);
    @(posedge clk); #1;
    ev_ack = 1'b0; flush = 1'b0;
    if (fl) begin
      sb_q.delete();
      mcount = 0;
    end else begin
      if (ack && mcount > 0) begin
        void'(sb_q.pop_front());
        mcount--;
      end
      if (mcount < DEPTH) begin
        sb_q.push_back({m, d});
        mcount++;
      end else begin
        mov = 1'b1;
      end
    end
    @(negedge clk);
    check("ret_lat", kb_data_retrieved, 1);
    if (was_empty && !fl) check("valid_lat", ev_valid, 1);
    seen = kb_data_retrieved;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = kb_data_retrieved;
    end
    if (!seen) check("ret_timeout", 0, 1);
    @(posedge clk); #1;
    for (int i = 0; i < extra; i++) begin
      @(posedge clk); #1;
    end
    kb_data_ready = 1'b0;
    @(posedge clk); #1;
    check("ret_once", ret_cnt - r0, 1);
    @(negedge clk);
    check("count", count, mcount);
    check("overflow", overflow, mov);
    check("irq", irq, (mcount != 0) || mov);
  endtask

  task automatic pop_event();
    @(negedge clk);
    check("pop_valid", ev_valid, 1);
    check("pop_head", {ev_is_mouse, ev_data}, sb_q[0]);
    ev_ack = 1'b1;
    @(posedge clk); #1;
    ev_ack = 1'b0;
    void'(sb_q.pop_front());
    mcount--;
    @(negedge clk);
    check("pop_count", count, mcount);
  endtask

  task automatic clear_overflow();
    @(posedge clk); #1;
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    mov = 1'b0;
    @(negedge clk);
    check("ovf_clr", overflow, 0);
    check("irq_after_clr", irq, mcount != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_count", count, 0);
    check("rst_valid", ev_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ret", kb_data_retrieved, 0);
    @(negedge clk);
    rst_n = 1'b1;
    irq_en = 1'b1;

    // 1: single key
    send_word(1'b0, 16'h6C05, 0, 1'b0, 1'b0);
    check("t1_data", ev_data, 16'h6C05);
    check("t1_mouse", ev_is_mouse, 0);
    pop_event();
    check("t1_irq_off", irq, 0);

    // 2: alternating tags, ready held 3 extra cycles
    send_word(1'b0, 16'h0001, 3, 1'b0, 1'b0);
    send_word(1'b1, 16'h0102, 3, 1'b0, 1'b0);
    send_word(1'b0, 16'h0203, 3, 1'b0, 1'b0);
    send_word(1'b1, 16'h0304, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop_event();

    // 3: overflow on the fifth word
    for (int i = 0; i < 4; i++) send_word(i[0], 16'h1000 + 16'(i), 0, 1'b0, 1'b0);
    send_word(1'b1, 16'hBEEF, 0, 1'b0, 1'b0);
    check("t3_count", count, 4);
    check("t3_ovf", overflow, 1);
    check("t3_head", {ev_is_mouse, ev_data}, {1'b0, 16'h1000});
    clear_overflow();

    // 4: full with simultaneous pop
    send_word(1'b1, 16'hA55A, 0, 1'b1, 1'b0);
    check("t4_count", count, 4);
    check("t4_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) pop_event();

    // 5: flush during capture with overflow set, then ack while empty
    for (int i = 0; i < 5; i++) send_word(1'b0, 16'h2000 + 16'(i), 0, 1'b0, 1'b0);
    send_word(1'b1, 16'h3333, 0, 1'b0, 1'b1);
    check("t5_count", count, 0);
    check("t5_ovf_kept", overflow, 1);
    check("t5_irq_ovf", irq, 1);
    clear_overflow();
    @(posedge clk); #1;
    ev_ack = 1'b1;
    @(posedge clk); #1;
    ev_ack = 1'b0;
    @(negedge clk);
    check("t5_empty_ack", count, 0);
    check("t5_empty_valid", ev_valid, 0);
    send_word(1'b0, 16'h4444, 0, 1'b0, 1'b0);
    pop_event();

    // 6: asynchronous reset while in ACK with two entries
    send_word(1'b0, 16'h5555, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    kb_data_ready = 1'b1; kb_is_mouse = 1'b1; kb_data = 16'h6666;
    @(posedge clk); #1;
    check("t6_in_ack", kb_data_retrieved, 1);
    check("t6_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ret", kb_data_retrieved, 0);
    check("t6_valid", ev_valid, 0);
    check("t6_count", count, 0);
    check("t6_irq", irq, 0);
    check("t6_ovf", overflow, 0);
    check("t6_data", {ev_is_mouse, ev_data}, 0);
    kb_data_ready = 1'b0;
    sb_q.delete();
    mcount = 0;
    mov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_word(1'b1, 16'h1234, 0, 1'b0, 1'b0);
    pop_event();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
